// File: rtl/yarp_pkg.sv
// yarp_pkg: shared types and constants for the YARP core branch-redirect slice.
package yarp_pkg;
  typedef enum logic [1:0] {BR_IDLE, BR_REDIR, BR_FLUSH} br_state_t;
  localparam logic [31:0] BR_PC_INC = 32'h4;
endpackage

// File: rtl/yarp_sat_counter.sv
// yarp_sat_counter: saturating up-counter with synchronous clear that wins over increment.
module yarp_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + WIDTH'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !reset_n ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/yarp_branch_redirect_ctrl.sv
// yarp_branch_redirect_ctrl: EX-stage mispredict redirect to fetch, IF/ID hold/flush and perf counters.
// Define YARP_BTFN_PRED_EN for backward-taken/forward-not-taken prediction; default is static not-taken.
module yarp_branch_redirect_ctrl
  import yarp_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid_i,
  input  logic        is_b_type_ctl_i,
  input  logic        branch_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic        fetch_ready_i,
  input  logic        perf_clr_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        hold_o,
  output logic        flush_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);
  br_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target, fallthru;
  logic        eval, pred_taken, mispred;
  assign eval     = (state_q == BR_IDLE) && ex_valid_i && is_b_type_ctl_i;
`ifdef YARP_BTFN_PRED_EN
  assign pred_taken = ex_imm_i[31];
`else
  assign pred_taken = 1'b0;
`endif
  assign mispred  = eval && (branch_taken_i != pred_taken);
  assign target   = ex_pc_i + ex_imm_i;
  assign fallthru = ex_pc_i + BR_PC_INC;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      BR_IDLE: if (mispred) begin
        pc_d    = (branch_taken_i ? target : fallthru) & ~32'h1;
        state_d = BR_REDIR;
      end
      BR_REDIR: if (fetch_ready_i) begin
        cnt_d   = 4'(FLUSH_CYCLES - 1);
        state_d = BR_FLUSH;
      end
      BR_FLUSH: if (cnt_q == 4'd0) state_d = BR_IDLE; else cnt_d = cnt_q - 4'd1;
      default: state_d = BR_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BR_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end
  // Outputs decode from state only, so fetch never sees a combinational path from EX.
  assign redirect_valid_o = (state_q == BR_REDIR);
  assign hold_o           = (state_q != BR_IDLE);
  assign flush_o          = (state_q != BR_IDLE);
  assign redirect_pc_o    = pc_q;
  yarp_sat_counter #(.WIDTH(32)) u_br_cnt (
    .clk(clk), .reset_n(reset_n), .inc_i(eval), .clr_i(perf_clr_i), .cnt_o(br_cnt_o)
  );
  yarp_sat_counter #(.WIDTH(32)) u_mis_cnt (
    .clk(clk), .reset_n(reset_n), .inc_i(mispred), .clr_i(perf_clr_i), .cnt_o(mispred_cnt_o)
  );
endmodule

// File: tb/tb_yarp_branch_redirect_ctrl.sv
// tb_yarp_branch_redirect_ctrl: directed vectors with hand-computed expectations.
module tb_yarp_branch_redirect_ctrl;
`ifdef YARP_BTFN_PRED_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif
  logic        clk = 0, reset_n = 0;
  logic        ex_valid_i = 0, is_b_type_ctl_i = 0, branch_taken_i = 0;
  logic        fetch_ready_i = 1, perf_clr_i = 0;
  logic [31:0] ex_pc_i = 0, ex_imm_i = 0;
  logic        redirect_valid_o, hold_o, flush_o;
  logic [31:0] redirect_pc_o, br_cnt_o, mispred_cnt_o;
  int          checks = 0, errors = 0;
  int          nv, nf;
  always #5 clk = ~clk;
  yarp_branch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid_i(ex_valid_i), .is_b_type_ctl_i(is_b_type_ctl_i),
    .branch_taken_i(branch_taken_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i),
    .fetch_ready_i(fetch_ready_i), .perf_clr_i(perf_clr_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .hold_o(hold_o), .flush_o(flush_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  // Presents one branch for a single cycle; returns at the negedge after the evaluating edge.
  task automatic branch(input logic [31:0] pc, input logic [31:0] imm, input logic tk, input logic clr);
    @(negedge clk);
    ex_valid_i = 1; is_b_type_ctl_i = 1; ex_pc_i = pc; ex_imm_i = imm; branch_taken_i = tk; perf_clr_i = clr;
    @(negedge clk);
    ex_valid_i = 0; is_b_type_ctl_i = 0; perf_clr_i = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (hold_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, hold_o}, 32'h0);
  endtask
  task automatic count_cycles(output int v, output int f);
    v = 0; f = 0;
    for (int i = 0; i < 6; i++) begin
      v += int'(redirect_valid_o);
      f += int'(flush_o);
      @(negedge clk);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, redirect_valid_o}, 32'h0);
    chk("rst_pc", redirect_pc_o, 32'h0);
    chk("rst_hold", {31'b0, hold_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    chk("rst_br", br_cnt_o, 32'h0);
    chk("rst_mis", mispred_cnt_o, 32'h0);
    reset_n = 1;
    // taken forward branch: mispredicted under both policies
    branch(32'h100, 32'h20, 1'b1, 1'b0);
    chk("fwd_pc", redirect_pc_o, 32'h120);
    chk("fwd_br", br_cnt_o, 32'd1);
    chk("fwd_mis", mispred_cnt_o, 32'd1);
    count_cycles(nv, nf);
    chk("fwd_valid_cycles", nv, 32'd1);
    chk("fwd_flush_cycles", nf, 32'd3);
    chk("fwd_idle", {31'b0, hold_o}, 32'h0);
    // odd target: bit 0 of the redirect is cleared
    branch(32'h100, 32'h21, 1'b1, 1'b0);
    chk("bit0_pc", redirect_pc_o, 32'h120);
    chk("bit0_valid", {31'b0, redirect_valid_o}, 32'h1);
    wait_idle();
    // backward taken
    branch(32'h200, 32'hFFFF_FFF0, 1'b1, 1'b0);
    chk("bwd_t_valid", {31'b0, redirect_valid_o}, BTFN ? 32'h0 : 32'h1);
    chk("bwd_t_pc", redirect_pc_o, BTFN ? 32'h120 : 32'h1F0);
    chk("bwd_t_br", br_cnt_o, 32'd3);
    chk("bwd_t_mis", mispred_cnt_o, BTFN ? 32'd2 : 32'd3);
    wait_idle();
    // backward not taken
    branch(32'h200, 32'hFFFF_FFF0, 1'b0, 1'b0);
    chk("bwd_nt_valid", {31'b0, redirect_valid_o}, BTFN ? 32'h1 : 32'h0);
    chk("bwd_nt_pc", redirect_pc_o, BTFN ? 32'h204 : 32'h1F0);
    chk("bwd_nt_mis", mispred_cnt_o, 32'd3);
    wait_idle();
    // wrap-around to address 0
    branch(32'hFFFF_FFFC, BTFN ? 32'hFFFF_FFF0 : 32'h4, !BTFN, 1'b0);
    chk("wrap_pc", redirect_pc_o, 32'h0);
    chk("wrap_valid", {31'b0, redirect_valid_o}, 32'h1);
    wait_idle();
    // handshake stall with a second branch presented during the stall
    fetch_ready_i = 0;
    branch(32'h300, 32'h40, 1'b1, 1'b0);
    ex_valid_i = 1; is_b_type_ctl_i = 1; ex_pc_i = 32'h800; ex_imm_i = 32'h10; branch_taken_i = 1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        fetch_ready_i = 1;
        ex_valid_i = 0; is_b_type_ctl_i = 0;
      end
      nv += int'(redirect_valid_o);
      if (redirect_valid_o) chk("stall_pc", redirect_pc_o, 32'h340);
      @(negedge clk);
    end
    chk("stall_valid_cycles", nv, 32'd6);
    chk("stall_br", br_cnt_o, 32'd6);
    chk("stall_mis", mispred_cnt_o, 32'd5);
    wait_idle();
    // reset while in REDIR aborts the sequence
    fetch_ready_i = 0;
    branch(32'h500, 32'h10, 1'b1, 1'b0);
    chk("pre_rst_valid", {31'b0, redirect_valid_o}, 32'h1);
    reset_n = 0;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", {31'b0, redirect_valid_o}, 32'h0);
    chk("mid_rst_pc", redirect_pc_o, 32'h0);
    chk("mid_rst_hold", {31'b0, hold_o}, 32'h0);
    chk("mid_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("mid_rst_br", br_cnt_o, 32'h0);
    chk("mid_rst_mis", mispred_cnt_o, 32'h0);
    reset_n = 1; fetch_ready_i = 1;
    count_cycles(nv, nf);
    chk("post_rst_valid_cycles", nv, 32'd0);
    chk("post_rst_flush_cycles", nf, 32'd0);
    // saturation of the branch counter
    @(negedge clk);
    force dut.u_br_cnt.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_br_cnt.cnt_q;
    branch(32'h400, 32'h8, 1'b0, 1'b0);
    chk("sat_br", br_cnt_o, 32'hFFFF_FFFF);
    chk("sat_mis", mispred_cnt_o, 32'h0);
    chk("sat_no_redirect", {31'b0, redirect_valid_o}, 32'h0);
    // clear wins over a same-cycle mispredict increment
    branch(32'h400, 32'h8, 1'b1, 1'b1);
    chk("clr_br", br_cnt_o, 32'h0);
    chk("clr_mis", mispred_cnt_o, 32'h0);
    chk("clr_pc", redirect_pc_o, 32'h408);
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/yarp_branch_redirect_ctrl.md
# yarp_branch_redirect_ctrl

Branch-resolution sequencer for the pipelined YARP core. It sits between the EX-stage branch comparator and the fetch unit. On a mispredicted conditional branch it computes the correct next PC and issues a redirect to fetch over a valid/ready handshake. It holds and flushes the younger IF/ID stages for a programmable number of cycles, and it keeps saturating branch/mispredict performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after the redirect handshake; legal range is 1–15.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- ex_valid_i  in  1  EX stage holds a valid instruction.
- is_b_type_ctl_i  in  1  EX instruction is a conditional branch.
- branch_taken_i  in  1  resolved outcome from the branch comparator.
- ex_pc_i  in  32  PC of the EX instruction.
- ex_imm_i  in  32  sign-extended B-type immediate.
- fetch_ready_i  in  1  fetch accepts the redirect this cycle.
- perf_clr_i  in  1  synchronous clear of both counters.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_pc_o  out  32  corrected PC; stable while redirect_valid_o is high.
- hold_o  out  1  freeze IF/ID; high in every non-IDLE state.
- flush_o  out  1  squash IF/ID contents.
- br_cnt_o  out  32  count of evaluated branches.
- mispred_cnt_o  out  32  count of mispredicted branches.

## Operation
- Evaluation takes place only in IDLE and only when ex_valid_i & is_b_type_ctl_i are both high. In all other states these inputs are ignored.
- Arithmetic:
  - target = ex_pc_i + ex_imm_i, 32-bit, with wrap-around.
  - fallthrough = ex_pc_i + 4, 32-bit, with wrap.
  - Bit 0 of the latched PC is forced to 0.
  - No misalignment check is done.
- Prediction, per Configuration: predicted_taken.
- mispredict = branch_taken_i != predicted_taken.
- Latched redirect PC: branch_taken_i ? target : fallthrough.
- FSM states:
  - IDLE:
    - On an evaluated branch with a mispredict, latch the redirect PC and go to REDIR.
    - On a correctly predicted branch, stay in IDLE.
  - REDIR:
    - redirect_valid_o=1, hold_o=1, flush_o=1.
    - When fetch_ready_i=1, the handshake completes. Load cnt=FLUSH_CYCLES-1 and go to FLUSH.
    - Otherwise stay in REDIR indefinitely with redirect_pc_o unchanged.
  - FLUSH:
    - flush_o=1, hold_o=1, redirect_valid_o=0.
    - When cnt==0, go to IDLE; otherwise decrement cnt.
- Counters:
  - br_cnt_o increments on every evaluated branch.
  - mispred_cnt_o increments on every mispredict.
  - Both saturate at 32'hFFFF_FFFF.
  - perf_clr_i sets both to 0 and takes priority over a same-cycle increment.
  - Counters are not frozen by hold_o.

## Timing
- Reset (reset_n low at a clock edge):
  - State goes to IDLE and cnt to 0.
  - redirect_valid_o=0, redirect_pc_o=0, hold_o=0, flush_o=0.
  - Both counters go to 0.
  - Reset in REDIR or FLUSH aborts the sequence with no redirect emitted afterwards.
- All outputs are registered or decoded from state. There is no input-to-output combinational path.
- Latency:
  - A mispredict evaluated in cycle N gives redirect_valid_o high from N+1.
  - A handshake in cycle M gives flush_o high through M+FLUSH_CYCLES.
  - IDLE is re-entered in cycle M+FLUSH_CYCLES+1.
- Minimum occupancy per mispredict, with fetch_ready_i tied high: 1 + FLUSH_CYCLES cycles.
- Counter outputs update on the cycle after the evaluating edge.
- A branch evaluated in the same cycle as IDLE re-entry is evaluated normally.

## Configuration
- YARP_BTFN_PRED_EN defined: backward-taken/forward-not-taken prediction.
  - predicted_taken = ex_imm_i[31].
  - A taken backward branch is not redirected.
  - A not-taken backward branch redirects to fallthrough.
- Undefined: predicted_taken = 0 (static not-taken).
  - Only taken branches redirect, always to target.
  - Fetch must match the same policy.

## Structure
- yarp_pkg additions:
  - typedef enum logic [1:0] {BR_IDLE, BR_REDIR, BR_FLUSH} br_state_t.
  - Constant BR_PC_INC = 32'h4.
- Sub-module yarp_sat_counter (WIDTH=32; inc, clr, cnt), instantiated twice.

## Test plan
- Reset:
  - Stimulus: drive reset_n=0 for 2 cycles while in REDIR.
  - Response: all outputs 0, state IDLE.
  - After release, no redirect until a new mispredict.
- Taken forward branch:
  - Stimulus: pc=0x100, imm=0x20, taken=1, fetch_ready_i=1, macro undefined.
  - Response: redirect_pc_o=0x120 for exactly 1 cycle, flush_o for 3 cycles, br_cnt=1, mispred_cnt=1.
- Backward-taken branch with YARP_BTFN_PRED_EN:
  - Taken case: pc=0x200, imm=0xFFFF_FFF0, taken=1 gives no redirect; br_cnt=1, mispred_cnt=0.
  - Not-taken case gives redirect_pc_o=0x204.
- Handshake stall:
  - Stimulus: fetch_ready_i=0 for 5 cycles, then 1.
  - Response: redirect_valid_o high for 6 cycles with a constant PC.
  - A second branch presented during the stall is ignored, with no count.
- Wrap-around:
  - Stimulus: pc=0xFFFF_FFFC, taken=0, BTFN with negative imm.
  - Response: redirect_pc_o=0x0000_0000.
- Counters:
  - Preload br_cnt to 0xFFFF_FFFF by force, then a branch gives a held value of 0xFFFF_FFFF.
  - perf_clr_i together with a mispredict gives both counters 0.
